// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM encodings and the latched request record for the
// 64x64 memory-bus initiator.
package mem_bus_pkg;

    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int DATA_W    = 64;
    localparam int LEN_W     = 3;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t WRITE = 2'd1;
    localparam state_t READ  = 2'd2;
    localparam state_t TURN  = 2'd3;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] wdata;
    } memReq_t;

endpackage

// File: rtl/mem_bus_io.sv
// DataBus pad logic: tristate write driver plus the read-sample register,
// so the FSM never touches the inout directly.
module mem_bus_io
    import mem_bus_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              driveEn,
    input  logic [DATA_W-1:0] wrData,
    input  logic              sampleEn,
    output logic [DATA_W-1:0] rdData,
    inout  wire  [DATA_W-1:0] DataBus
);

    assign DataBus = driveEn ? wrData : {DATA_W{1'bz}};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)        rdData <= '0;
        else if (sampleEn) rdData <= DataBus;
    end

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator: turns one-cycle client requests into single writes or
// incrementing read bursts, with idle turnaround after every transfer.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int TURN_CYC = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWr,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [LEN_W-1:0]  ReqLen,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              RspLast,
    output logic              Busy,
    output logic              MemWr,
    output logic              MemRd,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] DataBus
);

    state_t           state;
    memReq_t          reqQ;
    logic [LEN_W-1:0] beatCnt;
    logic [1:0]       latCnt;
    logic [1:0]       turnCnt;
    logic             beatEnd;
    logic             lastBeat;

    assign beatEnd  = (state == READ) && (latCnt == 2'(RD_LAT - 1));
    assign lastBeat = (beatCnt == reqQ.len);

    assign ReqReady = (state == IDLE);
    assign Busy     = (state != IDLE);
    assign MemWr    = (state == WRITE) && reqQ.wr;
    assign MemRd    = (state == READ);
    // Burst address is base + beat index; 6-bit add gives the 63->0 wrap.
    assign Addr     = reqQ.addr + ADDR_W'(beatCnt);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            reqQ     <= '0;
            beatCnt  <= '0;
            latCnt   <= '0;
            turnCnt  <= '0;
            RspValid <= 1'b0;
            RspLast  <= 1'b0;
        end else begin
            RspValid <= beatEnd;
            RspLast  <= beatEnd && lastBeat;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        reqQ    <= '{wr: ReqWr, addr: ReqAddr, len: ReqLen, wdata: ReqWData};
                        beatCnt <= '0;
                        latCnt  <= '0;
                        state   <= ReqWr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    turnCnt <= '0;
                    state   <= TURN;
                end
                READ: begin
                    if (beatEnd) begin
                        if (lastBeat) begin
                            turnCnt <= '0;
                            state   <= TURN;
                        end else begin
                            beatCnt <= beatCnt + 1'b1;
                            latCnt  <= '0;
                        end
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                TURN: begin
                    if (turnCnt == 2'(TURN_CYC - 1)) state <= IDLE;
                    else                             turnCnt <= turnCnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_bus_io uIo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .driveEn  (MemWr),
        .wrData   (reqQ.wdata),
        .sampleEn (beatEnd),
        .rdData   (RspData),
        .DataBus  (DataBus)
    );

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: table of transactions against an RD_LAT=1/TURN_CYC=2
// master, plus turnaround, mid-burst reset and an RD_LAT=3 instance.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int TCA = 2;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] expFirst;
        logic [DATA_W-1:0] expLast;
    } vec_t;

    typedef struct {
        int                t;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              l;
    } ev_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic              Rst_n;
    logic              ReqValid, ReqValidB, ReqWr;
    logic [ADDR_W-1:0] ReqAddr;
    logic [LEN_W-1:0]  ReqLen;
    logic [DATA_W-1:0] ReqWData;

    logic              ReqReady, RspValid, RspLast, Busy, MemWr, MemRd;
    logic [DATA_W-1:0] RspData;
    logic [ADDR_W-1:0] Addr;
    wire  [DATA_W-1:0] DataBus;

    logic              ReqReadyB, RspValidB, RspLastB, BusyB, MemWrB, MemRdB;
    logic [DATA_W-1:0] RspDataB;
    logic [ADDR_W-1:0] AddrB;
    wire  [DATA_W-1:0] DataBusB;

    mem_bus_master #(.RD_LAT(1), .TURN_CYC(TCA)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWr(ReqWr), .ReqAddr(ReqAddr), .ReqLen(ReqLen), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspData(RspData), .RspLast(RspLast), .Busy(Busy),
        .MemWr(MemWr), .MemRd(MemRd), .Addr(Addr), .DataBus(DataBus)
    );

    mem_bus_master #(.RD_LAT(3), .TURN_CYC(1)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValidB), .ReqReady(ReqReadyB),
        .ReqWr(ReqWr), .ReqAddr(ReqAddr), .ReqLen(ReqLen), .ReqWData(ReqWData),
        .RspValid(RspValidB), .RspData(RspDataB), .RspLast(RspLastB), .Busy(BusyB),
        .MemWr(MemWrB), .MemRd(MemRdB), .Addr(AddrB), .DataBus(DataBusB)
    );

    // Memory model: combinational read drive, write on the strobe edge.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    bit memInit = 1'b0;
    always @(posedge Clk) begin
        if (!memInit) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= DATA_W'(i);
            memInit <= 1'b1;
        end else if (MemWr) begin
            mem[Addr] <= DataBus;
        end
    end
    assign DataBus  = MemRd  ? mem[Addr]  : {DATA_W{1'bz}};
    assign DataBusB = MemRdB ? mem[AddrB] : {DATA_W{1'bz}};

    function automatic bit busFree(input logic [DATA_W-1:0] v);
        return (v === {DATA_W{1'bz}}) || (v === {DATA_W{1'b0}});
    endfunction

    // Event logger; t is the index of the cycle the event was seen in.
    int  nc = 0;
    int  invViol = 0;
    bit  monOn = 1'b0;
    ev_t rspQ[$];
    ev_t rdQ[$];
    ev_t wrQ[$];
    always @(negedge Clk) begin
        nc <= nc + 1;
        if (monOn) begin
            if (RspValid) rspQ.push_back('{nc + 1, Addr, RspData, RspLast});
            if (MemRd)    rdQ.push_back('{nc + 1, Addr, DataBus, 1'b0});
            if (MemWr)    wrQ.push_back('{nc + 1, Addr, DataBus, 1'b0});
            if ((MemWr && MemRd) || (MemRd && DataBus !== mem[Addr]) ||
                (!MemRd && !MemWr && !busFree(DataBus)))
                invViol <= invViol + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] refMem [MEM_DEPTH];
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkI(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic present(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                           input logic [DATA_W-1:0] wd, output int s);
        int g = 0;
        @(negedge Clk); #1;
        ReqWr = wr; ReqAddr = a; ReqLen = len; ReqWData = wd; ReqValid = 1'b1;
        while (!ReqReady && g < 100) begin
            @(negedge Clk); #1;
            g++;
        end
        if (!ReqReady) chkI("handshakeTimeout", g, 0);
        s = nc;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
    endtask

    task automatic waitReady(output int r);
        r = -1;
        for (int g = 0; g < 100; g++) begin
            @(negedge Clk); #1;
            if (ReqReady) begin
                r = nc;
                break;
            end
        end
        if (r < 0) chkI("readyTimeout", r, 0);
    endtask

    initial begin
        int s, s2, r, rb, ab, wb, nb;
        logic [DATA_W-1:0] ed;
        Rst_n = 1'b0; ReqValid = 1'b0; ReqValidB = 1'b0;
        ReqWr = 1'b0; ReqAddr = '0; ReqLen = '0; ReqWData = '0;
        for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = DATA_W'(i);

        vecs[0] = '{1'b1, 6'h05, 3'd0, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
        vecs[1] = '{1'b0, 6'h05, 3'd0, 64'h0, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{1'b0, 6'h3E, 3'd3, 64'h0, 64'h3E, 64'h01};
        vecs[3] = '{1'b1, 6'h3F, 3'd0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF};
        vecs[4] = '{1'b0, 6'h3D, 3'd2, 64'h0, 64'h3D, 64'h01234567_89ABCDEF};
        vecs[5] = '{1'b0, 6'h00, 3'd7, 64'h0, 64'h00, 64'h07};
        vecs[6] = '{1'b1, 6'h00, 3'd7, 64'h55AA55AA_00FF00FF, 64'h55AA55AA_00FF00FF, 64'h55AA55AA_00FF00FF};
        vecs[7] = '{1'b0, 6'h3F, 3'd1, 64'h0, 64'h01234567_89ABCDEF, 64'h55AA55AA_00FF00FF};

        repeat (3) @(negedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk); #1;
        monOn = 1'b1;
        chkI("rstMemWr", int'(MemWr), 0);
        chkI("rstMemRd", int'(MemRd), 0);
        chkI("rstReqReady", int'(ReqReady), 1);
        chkI("rstRspValid", int'(RspValid), 0);
        chkI("rstBusy", int'(Busy), 0);
        chkI("rstAddr", int'(Addr), 0);
        chk("rstRspData", RspData, '0);
        chkI("rstBusFree", int'(busFree(DataBus)), 1);

        for (int i = 0; i < 8; i++) begin
            rb = rspQ.size(); ab = rdQ.size(); wb = wrQ.size();
            present(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, s);
            waitReady(r);
            if (vecs[i].wr) begin
                chkI($sformatf("v%0d wrCount", i), wrQ.size() - wb, 1);
                if (wrQ.size() > wb) begin
                    chkI($sformatf("v%0d wrCycle", i), wrQ[wb].t, s + 1);
                    chkI($sformatf("v%0d wrAddr", i), int'(wrQ[wb].a), int'(vecs[i].addr));
                    chk($sformatf("v%0d wrData", i), wrQ[wb].d, vecs[i].expFirst);
                end
                chkI($sformatf("v%0d wrReady", i), r, s + 2 + TCA);
                refMem[vecs[i].addr] = vecs[i].wdata;
            end else begin
                nb = int'(vecs[i].len) + 1;
                chkI($sformatf("v%0d rspCount", i), rspQ.size() - rb, nb);
                chkI($sformatf("v%0d rdCycles", i), rdQ.size() - ab, nb);
                for (int k = 0; k < nb; k++) begin
                    ed = (k == 0) ? vecs[i].expFirst :
                         (k == nb - 1) ? vecs[i].expLast : refMem[ADDR_W'(int'(vecs[i].addr) + k)];
                    if (rb + k < rspQ.size()) begin
                        chkI($sformatf("v%0d b%0d rspCycle", i, k), rspQ[rb + k].t, s + 2 + k);
                        chk($sformatf("v%0d b%0d rspData", i, k), rspQ[rb + k].d, ed);
                        chkI($sformatf("v%0d b%0d rspLast", i, k), int'(rspQ[rb + k].l), int'(k == nb - 1));
                    end
                    if (ab + k < rdQ.size()) begin
                        chkI($sformatf("v%0d b%0d addr", i, k), int'(rdQ[ab + k].a), (int'(vecs[i].addr) + k) % 64);
                        chkI($sformatf("v%0d b%0d addrCycle", i, k), rdQ[ab + k].t, s + 1 + k);
                    end
                end
                chkI($sformatf("v%0d rdReady", i), r, s + nb + 1 + TCA);
            end
        end

        // Read burst with a write queued behind it.
        rb = rspQ.size(); ab = rdQ.size(); wb = wrQ.size();
        present(1'b0, 6'h10, 3'd1, 64'h0, s);
        present(1'b1, 6'h20, 3'd0, 64'hA5A5A5A5_5A5A5A5A, s2);
        waitReady(r);
        chkI("turnHoldOff", s2, s + 2 + 1 + TCA);
        chkI("turnRspCount", rspQ.size() - rb, 2);
        chkI("turnWrCount", wrQ.size() - wb, 1);
        if (wrQ.size() > wb && rdQ.size() >= ab + 2) begin
            chkI("turnGap", wrQ[wb].t - rdQ[ab + 1].t - 1, TCA + 1);
            chk("turnWrData", wrQ[wb].d, 64'hA5A5A5A5_5A5A5A5A);
        end
        if (rspQ.size() >= rb + 2) chk("turnRdData", rspQ[rb + 1].d, 64'h11);
        refMem[6'h20] = 64'hA5A5A5A5_5A5A5A5A;

        // Reset in the middle of an 8-beat burst.
        rb = rspQ.size();
        present(1'b0, 6'h08, 3'd7, 64'h0, s);
        for (int g = 0; g < 50 && rspQ.size() < rb + 2; g++) begin
            @(negedge Clk); #1;
        end
        chkI("midBeats", rspQ.size() - rb, 2);
        chkI("midMemRd", int'(MemRd), 1);
        #2 Rst_n = 1'b0;
        #1;
        chkI("asyncMemRd", int'(MemRd), 0);
        chkI("asyncMemWr", int'(MemWr), 0);
        chkI("asyncRspValid", int'(RspValid), 0);
        chkI("asyncBusy", int'(Busy), 0);
        chkI("asyncAddr", int'(Addr), 0);
        chkI("asyncBusFree", int'(busFree(DataBus)), 1);
        repeat (2) @(negedge Clk);
        #1 Rst_n = 1'b1;
        rb = rspQ.size();
        repeat (10) @(negedge Clk);
        #1;
        chkI("noRspAfterRst", rspQ.size() - rb, 0);
        chkI("idleAfterRst", int'(ReqReady), 1);

        // RD_LAT=3 instance: two beats from 0x10.
        @(negedge Clk); #1;
        ReqWr = 1'b0; ReqAddr = 6'h10; ReqLen = 3'd1; ReqValidB = 1'b1;
        chkI("bReady", int'(ReqReadyB), 1);
        @(posedge Clk); #1;
        ReqValidB = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge Clk); #1;
            chkI($sformatf("b c%0d MemRd", j), int'(MemRdB), int'(j <= 6));
            if (j <= 6) chkI($sformatf("b c%0d Addr", j), int'(AddrB), (j <= 3) ? 'h10 : 'h11);
            chkI($sformatf("b c%0d RspValid", j), int'(RspValidB), int'(j == 4 || j == 7));
            if (j == 4) chk("b beat0 data", RspDataB, 64'h10);
            if (j == 7) begin
                chk("b beat1 data", RspDataB, 64'h11);
                chkI("b beat1 last", int'(RspLastB), 1);
            end
            if (!MemRdB) chkI($sformatf("b c%0d busFree", j), int'(busFree(DataBusB)), 1);
        end

        chkI("invariants", invViol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the 64x64 memory bus: converts single-cycle requests from an internal client into MemWr/MemRd/Addr strobes and drives or samples the shared bidirectional DataBus.
- Supports single-beat writes and incrementing read bursts of 1-8 beats, with bus turnaround enforced.
- Sits between client logic (CPU/DMA) and the `memory` block; its DataBus port connects directly to the memory's DataBus.

Parameters:
- ADDR_W, 6, address width (64 words).
- DATA_W, 64, word width.
- RD_LAT, 1, cycles from Addr/MemRd valid to the DataBus sample point; legal range 1-4.
- TURN_CYC, 1, idle cycles with the bus released after any read burst or write; legal range 1-3.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  client request valid.
- ReqReady  out  1  master can accept a request.
- ReqWr  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_W  start address.
- ReqLen  in  3  read beats minus 1; ignored for writes.
- ReqWData  in  DATA_W  write data.
- RspValid  out  1  one-cycle pulse per read beat.
- RspData  out  DATA_W  read data, valid when RspValid=1.
- RspLast  out  1  marks the final beat of a burst.
- Busy  out  1  high in every state except IDLE.
- MemWr  out  1  memory write strobe.
- MemRd  out  1  memory read strobe.
- Addr  out  ADDR_W  memory address.
- DataBus  inout  DATA_W  shared bus; driven only during WRITE, otherwise high-Z.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - MemWr=0, MemRd=0, Addr=0, DataBus=Z.
  - RspValid=0, RspLast=0, RspData=0, Busy=0, ReqReady=1 after release.
  - Any burst in flight is abandoned with no further RspValid pulses.
- States: IDLE, WRITE, READ, TURN.
- IDLE:
  - ReqReady=1.
  - Handshake = ReqValid & ReqReady at a rising edge; address, data, length and direction are latched at that edge.
  - Next state is WRITE if ReqWr=1, else READ.
- WRITE (exactly 1 cycle):
  - MemWr=1, Addr=latched address, DataBus=latched data.
  - Next state TURN.
- READ:
  - MemRd=1 for the whole burst.
  - Each beat lasts RD_LAT cycles.
  - DataBus is sampled at the last edge of the beat; RspData/RspValid appear the following cycle.
  - Addr increments after each beat, modulo 64 (63 wraps to 0).
  - Beats = ReqLen+1.
  - After the final beat's sample edge: MemRd=0, state goes to TURN.
  - RspLast pulses with the final RspValid.
- TURN:
  - MemWr=0, MemRd=0, DataBus=Z for TURN_CYC cycles, then IDLE.
  - Addr holds its last value.
- ReqReady=0 in every state except IDLE; requests presented there are held off, not dropped.
- Invariants:
  - MemWr & MemRd is never 1.
  - DataBus is never driven while MemRd=1 or in TURN.
  - The final RspValid may coincide with the first TURN cycle.
- Latency with RD_LAT=1:
  - Read of N beats: handshake edge t; first RspValid in cycle t+2; subsequent beats back-to-back; ReqReady returns TURN_CYC cycles after MemRd drops.
  - Write: handshake edge t; MemWr high in cycle t+1; ReqReady high again in cycle t+2+TURN_CYC.
- No response backpressure: the client must accept every RspValid.

Decomposition:
- Package mem_bus_pkg:
  - ADDR_W, DATA_W, MEM_DEPTH=64.
  - State enum {IDLE, WRITE, READ, TURN}.
  - Request struct {wr, addr, len, wdata}.
- One sub-module, mem_bus_io: DataBus tristate driver plus sample register (inputs: drive enable, write data; output: sampled data). Keeps the inout off the FSM.

Test Plan:
- Reset then idle: Rst_n low for 3 cycles, then release → MemWr=MemRd=0, DataBus=Z, ReqReady=1, RspValid=0.
- Single write then read: write ReqAddr=05 with ReqWData=64'hDEADBEEF_CAFEF00D → MemWr high 1 cycle with Addr=05 and that value on DataBus; then read 05 with ReqLen=0 → one RspValid+RspLast with RspData=64'hDEADBEEF_CAFEF00D.
- Burst with wrap: preload memory with word[i]=i; read ReqAddr=3E, ReqLen=3 → Addr sequence 3E,3F,00,01 and 4 consecutive RspValid with data 3E,3F,00,01; RspLast on the 4th only.
- Turnaround: read burst immediately followed by a queued write → ReqReady low until TURN completes; DataBus never driven while MemRd=1; at least TURN_CYC Z cycles between MemRd falling and MemWr rising.
- Reset mid-burst: read ReqLen=7, assert Rst_n low after beat 2 → all strobes 0 immediately (asynchronously), no further RspValid, IDLE after release.
- RD_LAT=3 build: read ReqLen=1 at 10 → Addr=10 held 3 cycles, then 11 held 3 cycles; RspValid exactly 3 cycles apart.
